// File: rtl/i2s_adc_rx_if.sv
// Stereo frame handshake between the I2S capture path (master) and its consumer (slave).
`timescale 1ns/1ps
interface i2s_adc_rx_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] l_sample;
    logic [SAMPLE_W-1:0] r_sample;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output l_sample,
        output r_sample,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  l_sample,
        input  r_sample,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S ADC deserialiser: oversamples bclk/lrclk/sdata and emits stereo frames; SYNC_STAGES+2 sys_clk pin-to-valid.
// Backpressure: a single held frame; a frame completing while one is held and not taken is dropped and flags overflow.
`timescale 1ns/1ps
module i2s_adc_rx #(
    parameter int SAMPLE_W    = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          ac_bclk,
    input  logic          ac_lrclk,
    input  logic          ac_adc_sdata,
    i2s_adc_rx_if.master  frm,
    output logic          overflow,
    input  logic          ovf_clr
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    typedef enum logic [1:0] {
        WAIT_L,
        RX_L,
        RX_R
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_s;
    logic                   bclk_q;
    logic                   rise_q;
    logic                   lr_q;
    logic                   d_q;
    logic                   lr_prev;

    logic [SAMPLE_W-1:0]    shreg;
    logic [SAMPLE_W-1:0]    shreg_nxt;
    logic [SAMPLE_W-1:0]    l_hold;
    logic [CNT_W-1:0]       cnt;
    state_t                 state;

    logic                   word_edge;
    logic                   complete;
    logic                   drop;

    assign bclk_s = bclk_sync[SYNC_STAGES-1];

    // Registering the detected rise together with lr/data keeps them aligned.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            lr_q      <= 1'b0;
            d_q       <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], ac_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], ac_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], ac_adc_sdata};
            bclk_q    <= bclk_s;
            rise_q    <= bclk_s & ~bclk_q;
            lr_q      <= lr_sync[SYNC_STAGES-1];
            d_q       <= sd_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        shreg_nxt = shreg;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (int'(cnt) == SAMPLE_W - 1 - i) begin
                shreg_nxt[i] = d_q;
            end
        end
        word_edge = rise_q & (lr_q != lr_prev);
        complete  = word_edge & (state == RX_R) & ~lr_q;
        drop      = complete & frm.out_valid & ~frm.out_ready;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lr_prev       <= 1'b0;
            shreg         <= '0;
            cnt           <= '0;
            l_hold        <= '0;
            state         <= WAIT_L;
            frm.l_sample  <= '0;
            frm.r_sample  <= '0;
            frm.out_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (rise_q) begin
                lr_prev <= lr_q;
                // The edge rise carries the old word's LSB, so the word closes here.
                if (word_edge) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else begin
                    shreg <= shreg_nxt;
                    if (cnt != CNT_W'(SAMPLE_W)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            if (word_edge) begin
                case (state)
                    WAIT_L: if (!lr_q) state <= RX_L;
                    RX_L: begin
                        if (lr_q) begin
                            l_hold <= shreg_nxt;
                            state  <= RX_R;
                        end
                    end
                    RX_R:    if (!lr_q) state <= RX_L;
                    default: state <= WAIT_L;
                endcase
            end

            if (complete) begin
                if (!frm.out_valid || frm.out_ready) begin
                    frm.l_sample  <= l_hold;
                    frm.r_sample  <= shreg_nxt;
                    frm.out_valid <= 1'b1;
                end
            end else if (frm.out_valid && frm.out_ready) begin
                frm.out_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_adc_rx.sv
`timescale 1ns/1ps
module tb_i2s_adc_rx;
    localparam int SW = 24;
    localparam int SS = 2;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic ac_bclk, ac_lrclk, ac_adc_sdata;
    logic overflow, ovf_clr;

    i2s_adc_rx_if #(.SAMPLE_W(SW)) frm ();

    i2s_adc_rx #(.SAMPLE_W(SW), .SYNC_STAGES(SS)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .ac_bclk      (ac_bclk),
        .ac_lrclk     (ac_lrclk),
        .ac_adc_sdata (ac_adc_sdata),
        .frm          (frm),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } frame_t;

    typedef struct {
        int          n;
        logic [31:0] lw;
        logic [31:0] rw;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     half   = 4;
    logic   last_bit;
    logic   rnd_mode;
    logic   tb_rdy;
    frame_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a word of n bits lands MSB-aligned in 24 bits, truncated or zero-padded.
    function automatic logic [23:0] fit(input logic [31:0] w, input int n);
        logic [63:0] wm;
        wm = {32'h0, w} & ((64'd1 << n) - 64'd1);
        if (n >= 24) wm = wm >> (n - 24);
        else         wm = wm << (24 - n);
        return wm[23:0];
    endfunction

    // Consumer: picks ready, then records the frame taken at the next posedge.
    initial begin
        logic   r;
        frame_t e;
        frm.out_ready = 1'b0;
        forever begin
            @(negedge sys_clk);
            r = rnd_mode ? 1'($urandom_range(0, 1)) : tb_rdy;
            frm.out_ready = r;
            if (sys_rst_n && frm.out_valid && r) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_frame actual=%0h_%0h required=none",
                             frm.l_sample, frm.r_sample);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", {16'h0, frm.l_sample, frm.r_sample}, {16'h0, e.l, e.r});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic send_rise(input logic lr, input logic d);
        ac_bclk      = 1'b0;
        ac_lrclk     = lr;
        ac_adc_sdata = d;
        repeat (half) @(negedge sys_clk);
        ac_bclk = 1'b1;
        repeat (half) @(negedge sys_clk);
    endtask

    // The data line lags lrclk by one bit clock.
    task automatic send_word(input logic lr, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_rise(lr, last_bit);
            last_bit = w[n-1-i];
        end
    endtask

    task automatic send_frame(input int nl, input logic [31:0] lw, input int nr,
                              input logic [31:0] rw, input bit push);
        frame_t f;
        f.l = fit(lw, nl);
        f.r = fit(rw, nr);
        if (push) exp_q.push_back(f);
        send_word(1'b0, lw, nl);
        send_word(1'b1, rw, nr);
    endtask

    task automatic flush();
        send_word(1'b0, $urandom, 2);
    endtask

    task automatic preamble(input bit start_left);
        if (start_left) send_word(1'b0, $urandom, 5);
        send_word(1'b1, $urandom, 3 + int'($urandom_range(0, 9)));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        chk("reset_state", {14'h0, frm.out_valid, overflow, frm.l_sample, frm.r_sample}, 64'h0);
        sys_rst_n = 1'b1;
        last_bit  = 1'($urandom);
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        rnd_mode = 1'b1;
        while (exp_q.size() != 0 && w < 3000) begin
            @(negedge sys_clk);
            w++;
        end
        chk({nm, "_drain"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] a, b, f4l, f4r;
        frame_t      f;
        int          lat, nl, nr;

        vecs[0] = '{16, 32'h0000_8001, 32'h0000_7FFE, 24'h800100, 24'h7FFE00};
        vecs[1] = '{32, 32'h1234_5678, 32'h9ABC_DEF0, 24'h123456, 24'h9ABCDE};
        vecs[2] = '{24, 32'h00AB_CDEF, 32'h0000_0001, 24'hABCDEF, 24'h000001};
        vecs[3] = '{25, 32'h01FF_FFFF, 32'h0100_0000, 24'hFFFFFF, 24'h800000};
        vecs[4] = '{23, 32'h007F_FFFF, 32'h0040_0001, 24'hFFFFFE, 24'h800002};
        vecs[5] = '{2,  32'h0000_0002, 32'h0000_0003, 24'h800000, 24'hC00000};

        sys_rst_n = 1'b0; ac_bclk = 1'b0; ac_lrclk = 1'b0; ac_adc_sdata = 1'b0;
        ovf_clr = 1'b0; rnd_mode = 1'b0; tb_rdy = 1'b0; last_bit = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Slow bclk, 32-bit slots, start mid-right; measure pin-to-valid latency.
        half = 16; rnd_mode = 1'b0; tb_rdy = 1'b0;
        do_reset();
        preamble(1'b0);
        send_frame(32, {24'hA5A5A5, 8'($urandom)}, 32, {24'h5A5A5A, 8'($urandom)}, 1'b1);
        chk("t1_no_early_valid", 64'(frm.out_valid), 64'h0);
        ac_bclk = 1'b0; ac_lrclk = 1'b0; ac_adc_sdata = last_bit;
        repeat (half) @(negedge sys_clk);
        ac_bclk = 1'b1;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge sys_clk);
            #1;
            if (frm.out_valid && lat < 0) lat = c;
        end
        @(negedge sys_clk);
        chk("t1_latency", 64'(lat), 64'(SS + 2));
        chk("t1_held", {16'h0, frm.l_sample, frm.r_sample}, {16'h0, 24'hA5A5A5, 24'h5A5A5A});
        drain("t1");
        repeat (300) @(negedge sys_clk);
        chk("stuck_bclk_quiet", 64'(frm.out_valid), 64'h0);

        // Start mid-left: nothing until a full pair, first frame exact.
        half = 4;
        do_reset();
        rnd_mode = 1'b1;
        preamble(1'b1);
        send_frame(24, $urandom, 24, $urandom, 1'b1);
        chk("t2_no_partial_frame", 64'(frm.out_valid), 64'h0);
        send_frame(24, $urandom, 24, $urandom, 1'b1);
        flush();
        drain("t2");

        // Table of slot widths: truncation and zero padding.
        do_reset();
        rnd_mode = 1'b1;
        preamble(1'b0);
        for (int i = 0; i < 6; i++) begin
            f.l = vecs[i].el;
            f.r = vecs[i].er;
            exp_q.push_back(f);
            send_frame(vecs[i].n, vecs[i].lw, vecs[i].n, vecs[i].rw, 1'b0);
        end
        flush();
        drain("table");

        // Random widths and data under random backpressure.
        do_reset();
        rnd_mode = 1'b1;
        preamble(1'($urandom));
        for (int i = 0; i < 24; i++) begin
            nl = int'($urandom_range(8, 32));
            nr = int'($urandom_range(8, 32));
            send_frame(nl, $urandom, nr, $urandom, 1'b1);
        end
        flush();
        drain("random");
        chk("random_no_overflow", 64'(overflow), 64'h0);

        // Three frames with no consumer: first kept, later ones dropped.
        do_reset();
        rnd_mode = 1'b0; tb_rdy = 1'b0;
        preamble(1'b0);
        a = $urandom; b = $urandom;
        f4l = $urandom; f4r = $urandom;
        send_frame(24, a, 24, b, 1'b1);
        send_frame(24, $urandom, 24, $urandom, 1'b0);
        send_frame(24, $urandom, 24, $urandom, 1'b0);
        send_word(1'b0, f4l, 24);
        chk("t4_held_f1", {14'h0, frm.out_valid, overflow, frm.l_sample, frm.r_sample},
            {14'h0, 1'b1, 1'b1, a[23:0], b[23:0]});
        ovf_clr = 1'b1;
        @(negedge sys_clk);
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", {62'h0, frm.out_valid, overflow}, {62'h0, 1'b1, 1'b0});
        tb_rdy = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("t4_f1_taken", {31'h0, frm.out_valid, 32'(exp_q.size())}, 64'h0);
        f.l = f4l[23:0];
        f.r = f4r[23:0];
        exp_q.push_back(f);
        send_word(1'b1, f4r, 24);
        flush();
        drain("t4_f4");

        // Accept lands on the same cycle the next frame completes.
        do_reset();
        rnd_mode = 1'b0; tb_rdy = 1'b0;
        preamble(1'b0);
        a = $urandom; b = $urandom;
        send_frame(24, $urandom, 24, $urandom, 1'b1);
        send_frame(24, a, 24, b, 1'b1);
        ac_bclk = 1'b0; ac_lrclk = 1'b0; ac_adc_sdata = last_bit;
        repeat (half) @(negedge sys_clk);
        ac_bclk = 1'b1;
        repeat (SS + 1) @(posedge sys_clk);
        tb_rdy = 1'b1;
        @(posedge sys_clk);
        tb_rdy = 1'b0;
        @(negedge sys_clk);
        chk("t5_coincide", {14'h0, frm.out_valid, overflow, frm.l_sample, frm.r_sample},
            {14'h0, 1'b1, 1'b0, a[23:0], b[23:0]});
        chk("t5_f1_taken", 64'(exp_q.size()), 64'h1);
        repeat (half - 1) @(negedge sys_clk);
        drain("t5");

        // Asynchronous reset in the middle of a right word, then recovery.
        do_reset();
        rnd_mode = 1'b0; tb_rdy = 1'b0;
        preamble(1'b0);
        a = $urandom; b = $urandom;
        send_frame(24, a, 24, b, 1'b0);
        send_word(1'b0, $urandom, 24);
        send_word(1'b1, $urandom, 12);
        chk("t6_pre_reset", {15'h0, frm.out_valid, frm.l_sample, frm.r_sample},
            {15'h0, 1'b1, a[23:0], b[23:0]});
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {14'h0, frm.out_valid, overflow, frm.l_sample, frm.r_sample}, 64'h0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_word(1'b1, $urandom, 12);
        send_frame(24, $urandom, 24, $urandom, 1'b1);
        chk("t6_no_stale_frame", 64'(frm.out_valid), 64'h0);
        tb_rdy = 1'b1;
        flush();
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
